hazard_unit: RTL and testbench
==============================

Name: hazard_unit

Overview:
- Hazard and forwarding controller for the 5-stage ARM pipeline; produces the signals the pipeline currently takes as free-running inputs: pc_enable, if_id_enable, the cu_mux select (NOP insertion), IF/ID flush and operand-forwarding selects.
- Sits beside the ID stage.
- Keeps its own shadow of the destination register, write-enable and load flag of the instructions in EX/MEM/WB. This shadow advances every clock, in lock-step with id_ex_reg, ex_mem_reg and mem_wb_reg.

Parameters:
- REG_W, 4, register-address width (R0–R15).
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- id_rn  in  REG_W  first source register of the instruction in ID.
- id_rm  in  REG_W  second source register (register-offset or shifter operand).
- id_rd_src  in  REG_W  store-data source register (STR/STRB).
- id_use_rn  in  1  id_rn is read.
- id_use_rm  in  1  id_rm is read.
- id_use_rd  in  1  id_rd_src is read.
- id_reg_write  in  1  reg_write_enable from control_unit for the ID instruction.
- id_load  in  1  mem_read_enable from control_unit (LDR/LDRB).
- id_dest  in  REG_W  destination register of the ID instruction.
- id_branch_taken  in  1  B/BL in ID with its condition passed.
- pc_enable  out  1  program_counter enable.
- if_id_enable  out  1  if_id_reg enable.
- cu_nop_select  out  1  cu_mux select; 1 zeros all control into ID/EX.
- if_id_flush  out  1  squash the instruction in IF/ID (load NOP).
- fwd_a  out  2  forward select for the Rn operand.
- fwd_b  out  2  forward select for the Rm operand.
- fwd_c  out  2  forward select for the store-data operand.
- stall_count  out  CNT_W  number of load-use stall cycles since reset, saturating.

Behaviour:
- Reset is synchronous, sampled on the rising clk edge.
- While reset is high:
  - All shadow valid/write-enable bits and stall_count are cleared to 0.
  - Outputs are forced to pc_enable=0, if_id_enable=1, cu_nop_select=1, if_id_flush=0, fwd_a=fwd_b=fwd_c=00.
- Shadow pipeline: three registered stages, EX, MEM and WB. Each stage holds dest[REG_W-1:0], we and load.
  - Each clock, WB takes MEM's contents and MEM takes EX's.
  - EX takes {id_dest, id_reg_write, id_load}, or a bubble {0,0,0} when cu_nop_select=1.
- Load-use stall (combinational, 0-cycle latency):
  - Condition: ex.we and ex.load are set, ex.dest != 15, and ex.dest equals any used source (id_rn & id_use_rn, id_rm & id_use_rm, id_rd_src & id_use_rd).
  - Response: pc_enable=0, if_id_enable=0, cu_nop_select=1.
  - Duration: exactly one cycle. Next cycle the load is in MEM, the condition clears and the value is forwarded from MEM.
- No stall: pc_enable=1, if_id_enable=1, cu_nop_select=0.
- Forwarding, evaluated per operand (a=Rn, b=Rm, c=store data):
  - Unused operand → 00.
  - Source R15 → always 00; the PC is never forwarded.
  - Otherwise first match wins, in priority EX(01) > MEM(10) > WB(11) > register file(00).
  - A stage matches when its we=1 and its dest equals the operand's source register.
  - During a stall, the EX match is the stalled load; fwd values are don't-care because the ID instruction is bubbled.
- Branch flush: id_branch_taken=1 and no stall → if_id_flush=1 for that cycle. The wrong-path fetch is squashed and the PC redirect is handled by pc_src.
- Branch and load-use stall in the same cycle: the stall wins and if_id_flush=0. The branch stays in ID and re-asserts next cycle.
- stall_count increments by 1 on each stall cycle and holds at 2^CNT_W−1.
- Reset asserted mid-stall: the stall drops in the same cycle the reset is sampled, and the shadow stages become bubbles.

Decomposition:
- Package hazard_pkg holds:
  - FWD_RF=2'b00, FWD_EX=2'b01, FWD_MEM=2'b10, FWD_WB=2'b11.
  - REG_PC=4'd15.
  - Shadow-stage struct {dest, we, load}.
- Sub-module hazard_shadow_pipe holds the three-stage dest/we/load shift register with a bubble input.
- The top level holds the stall/forward/flush logic and the counter.

Test Plan:
- Reset held 3 cycles → pc_enable=0, cu_nop_select=1, stall_count=0. After release, with no dependencies → pc_enable=1, if_id_enable=1, cu_nop_select=0.
- ADD R5 (we=1, dest=5) followed by an ID instruction with id_rn=5, id_use_rn=1 → fwd_a=01. One cycle later (that ADD now in MEM), a new ID with rn=5 → fwd_a=10. Two cycles later → fwd_a=11.
- LDRB R2 in EX (load=1, dest=2), ID has id_rm=2, id_use_rm=1:
  - Stall cycle → pc_enable=0, if_id_enable=0, cu_nop_select=1, stall_count=1.
  - Next cycle → no stall, fwd_b=10.
- Store-data dependency: ADD R5 in EX, STR with id_rd_src=5, id_use_rd=1 → fwd_c=01. The same case with source 15 and EX dest=15 → fwd_c=00.
- BNE taken (id_branch_taken=1), no hazard → if_id_flush=1 for exactly one cycle.
- The same BNE while a load-use stall is active → if_id_flush=0 in the stall cycle, then 1 in the following cycle.
- Force 2^16 stall cycles → stall_count saturates at 16'hFFFF.
- Assert reset during a stall → stall_count=0 and all shadow stages are bubbles on the next edge.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared constants, shadow-stage record and forwarding-select helper for the
// ARM pipeline hazard controller.
package hazard_pkg;

  localparam int SHADOW_REG_W = 4;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  localparam logic [SHADOW_REG_W-1:0] REG_PC = 4'd15;

  typedef struct packed {
    logic [SHADOW_REG_W-1:0] dest;
    logic                    we;
    logic                    load;
  } shadow_t;

  // Youngest producer wins; the PC is always read from the PC path itself.
  function automatic logic [1:0] fwd_sel(
    input logic [SHADOW_REG_W-1:0] src,
    input logic                    used,
    input shadow_t                 ex,
    input shadow_t                 mem,
    input shadow_t                 wb
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (used && src != REG_PC) begin
      if (ex.we && ex.dest == src)        sel = FWD_EX;
      else if (mem.we && mem.dest == src) sel = FWD_MEM;
      else if (wb.we && wb.dest == src)   sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_shadow_pipe.sv
// Three-stage shadow of dest/we/load for the instructions in EX, MEM and WB,
// advancing in lock-step with the real pipeline registers.
module hazard_shadow_pipe
  import hazard_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    bubble_i,
  input  shadow_t id_i,
  output shadow_t ex_o,
  output shadow_t mem_o,
  output shadow_t wb_o
);

  shadow_t ex_q, mem_q, wb_q;
  shadow_t ex_d;

  // A NOP-selected cu_mux means ID/EX receives zeroed control.
  assign ex_d = bubble_i ? shadow_t'('0) : id_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end
  end

  assign ex_o  = ex_q;
  assign mem_o = mem_q;
  assign wb_o  = wb_q;

endmodule

// File: rtl/hazard_unit.sv
// Load-use stall, branch flush and operand forwarding for the 5-stage ARM
// pipeline, plus a saturating count of load-use stall cycles.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int REG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic [REG_W-1:0] id_rd_src,
  input  logic             id_use_rn,
  input  logic             id_use_rm,
  input  logic             id_use_rd,
  input  logic             id_reg_write,
  input  logic             id_load,
  input  logic [REG_W-1:0] id_dest,
  input  logic             id_branch_taken,
  output logic             pc_enable,
  output logic             if_id_enable,
  output logic             cu_nop_select,
  output logic             if_id_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [1:0]       fwd_c,
  output logic [CNT_W-1:0] stall_count
);

  shadow_t id_s, ex_s, mem_s, wb_s;
  logic    src_hit;
  logic    load_use;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  assign id_s = '{dest: id_dest, we: id_reg_write, load: id_load};

  hazard_shadow_pipe u_shadow (
    .clk      (clk),
    .reset    (reset),
    .bubble_i (cu_nop_select),
    .id_i     (id_s),
    .ex_o     (ex_s),
    .mem_o    (mem_s),
    .wb_o     (wb_s)
  );

  assign src_hit = (id_use_rn && id_rn     == ex_s.dest) ||
                   (id_use_rm && id_rm     == ex_s.dest) ||
                   (id_use_rd && id_rd_src == ex_s.dest);

  // One bubble suffices: next cycle the load sits in MEM and is forwarded.
  assign load_use = !reset && ex_s.we && ex_s.load && ex_s.dest != REG_PC && src_hit;

  always_comb begin
    pc_enable     = 1'b1;
    if_id_enable  = 1'b1;
    cu_nop_select = 1'b0;
    if_id_flush   = 1'b0;
    fwd_a         = fwd_sel(id_rn,     id_use_rn, ex_s, mem_s, wb_s);
    fwd_b         = fwd_sel(id_rm,     id_use_rm, ex_s, mem_s, wb_s);
    fwd_c         = fwd_sel(id_rd_src, id_use_rd, ex_s, mem_s, wb_s);
    if (reset) begin
      pc_enable     = 1'b0;
      cu_nop_select = 1'b1;
      fwd_a         = FWD_RF;
      fwd_b         = FWD_RF;
      fwd_c         = FWD_RF;
    end else if (load_use) begin
      // A taken branch held in ID re-asserts once the stall clears.
      pc_enable     = 1'b0;
      if_id_enable  = 1'b0;
      cu_nop_select = 1'b1;
    end else begin
      if_id_flush   = id_branch_taken;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (load_use && stall_cnt_q != {CNT_W{1'b1}})
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed-vector bench for hazard_unit; a second, narrow-counter instance
// shares the stimulus so counter saturation is reachable in few cycles.
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] id_rn, id_rm, id_rd_src, id_dest;
  logic       id_use_rn, id_use_rm, id_use_rd, id_reg_write, id_load, id_branch_taken;
  logic       pc_enable, if_id_enable, cu_nop_select, if_id_flush;
  logic [1:0] fwd_a, fwd_b, fwd_c;
  logic [15:0] stall_count;
  logic       s_pc_enable, s_if_id_enable, s_cu_nop_select, s_if_id_flush;
  logic [1:0] s_fwd_a, s_fwd_b, s_fwd_c;
  logic [3:0] s_stall_count;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  hazard_unit #(.REG_W(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .id_rn(id_rn), .id_rm(id_rm), .id_rd_src(id_rd_src),
    .id_use_rn(id_use_rn), .id_use_rm(id_use_rm), .id_use_rd(id_use_rd),
    .id_reg_write(id_reg_write), .id_load(id_load), .id_dest(id_dest),
    .id_branch_taken(id_branch_taken),
    .pc_enable(pc_enable), .if_id_enable(if_id_enable),
    .cu_nop_select(cu_nop_select), .if_id_flush(if_id_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_c(fwd_c), .stall_count(stall_count)
  );

  hazard_unit #(.REG_W(4), .CNT_W(4)) dut_small (
    .clk(clk), .reset(reset),
    .id_rn(id_rn), .id_rm(id_rm), .id_rd_src(id_rd_src),
    .id_use_rn(id_use_rn), .id_use_rm(id_use_rm), .id_use_rd(id_use_rd),
    .id_reg_write(id_reg_write), .id_load(id_load), .id_dest(id_dest),
    .id_branch_taken(id_branch_taken),
    .pc_enable(s_pc_enable), .if_id_enable(s_if_id_enable),
    .cu_nop_select(s_cu_nop_select), .if_id_flush(s_if_id_flush),
    .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .fwd_c(s_fwd_c), .stall_count(s_stall_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [3:0] rn, input logic urn, input logic [3:0] rm,
                        input logic urm, input logic [3:0] rd, input logic urd,
                        input logic we, input logic ld, input logic [3:0] dest,
                        input logic br);
    id_rn = rn; id_use_rn = urn; id_rm = rm; id_use_rm = urm;
    id_rd_src = rd; id_use_rd = urd; id_reg_write = we; id_load = ld;
    id_dest = dest; id_branch_taken = br;
  endtask

  task automatic idle();
    set_id(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_id(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
    repeat (3) tick();
    n_total++; if (pc_enable !== 1'b0) $display("FAIL reset_pc: got %b want 0", pc_enable); else n_pass++;
    n_total++; if (if_id_enable !== 1'b1) $display("FAIL reset_ifid: got %b want 1", if_id_enable); else n_pass++;
    n_total++; if (cu_nop_select !== 1'b1) $display("FAIL reset_nop: got %b want 1", cu_nop_select); else n_pass++;
    n_total++; if (if_id_flush !== 1'b0) $display("FAIL reset_flush: got %b want 0", if_id_flush); else n_pass++;
    n_total++; if (stall_count !== 16'd0) $display("FAIL reset_cnt: got %0d want 0", stall_count); else n_pass++;
    reset = 1'b0;
    idle();
    #1;
    n_total++; if (pc_enable !== 1'b1) $display("FAIL release_pc: got %b want 1", pc_enable); else n_pass++;
    n_total++; if (if_id_enable !== 1'b1) $display("FAIL release_ifid: got %b want 1", if_id_enable); else n_pass++;
    n_total++; if (cu_nop_select !== 1'b0) $display("FAIL release_nop: got %b want 0", cu_nop_select); else n_pass++;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_forward();
    set_id(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd5, 1'b0);  // ADD R5
    tick();
    set_id(4'd5, 1'b1, 4'd5, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    #1;
    n_total++; if (fwd_a !== 2'b01) $display("FAIL fwd_ex: got %b want 01", fwd_a); else n_pass++;
    tick();
    n_total++; if (fwd_a !== 2'b10) $display("FAIL fwd_mem: got %b want 10", fwd_a); else n_pass++;
    tick();
    n_total++; if (fwd_a !== 2'b11) $display("FAIL fwd_wb: got %b want 11", fwd_a); else n_pass++;
    n_total++; if (fwd_b !== 2'b00) $display("FAIL fwd_unused: got %b want 00", fwd_b); else n_pass++;
    tick();
    n_total++; if (fwd_a !== 2'b00) $display("FAIL fwd_rf: got %b want 00", fwd_a); else n_pass++;
    set_id(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd7, 1'b0);  // ADD R7 twice
    tick();
    tick();
    set_id(4'd7, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    #1;
    n_total++; if (fwd_a !== 2'b01) $display("FAIL fwd_prio: got %b want 01", fwd_a); else n_pass++;
    tick();
    $display("test_forward done");
  endtask

  task automatic test_load_use();
    set_id(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 4'd2, 1'b0);  // LDRB R2
    tick();
    set_id(4'd0, 1'b0, 4'd2, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    #1;
    n_total++; if (pc_enable !== 1'b0) $display("FAIL lu_pc: got %b want 0", pc_enable); else n_pass++;
    n_total++; if (if_id_enable !== 1'b0) $display("FAIL lu_ifid: got %b want 0", if_id_enable); else n_pass++;
    n_total++; if (cu_nop_select !== 1'b1) $display("FAIL lu_nop: got %b want 1", cu_nop_select); else n_pass++;
    tick();
    n_total++; if (stall_count !== 16'd1) $display("FAIL lu_cnt: got %0d want 1", stall_count); else n_pass++;
    n_total++; if (pc_enable !== 1'b1) $display("FAIL lu_clear: got %b want 1", pc_enable); else n_pass++;
    n_total++; if (fwd_b !== 2'b10) $display("FAIL lu_fwd: got %b want 10", fwd_b); else n_pass++;
    tick();
    set_id(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 4'd15, 1'b0); // LDR PC
    tick();
    set_id(4'd15, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    #1;
    n_total++; if (pc_enable !== 1'b1) $display("FAIL lu_pc15: got %b want 1", pc_enable); else n_pass++;
    n_total++; if (fwd_a !== 2'b00) $display("FAIL lu_fwd15: got %b want 00", fwd_a); else n_pass++;
    tick();
    $display("test_load_use done");
  endtask

  task automatic test_store();
    set_id(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd5, 1'b0);  // ADD R5
    tick();
    set_id(4'd0, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    #1;
    n_total++; if (fwd_c !== 2'b01) $display("FAIL st_fwd: got %b want 01", fwd_c); else n_pass++;
    tick();
    set_id(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd15, 1'b0); // writes R15
    tick();
    set_id(4'd0, 1'b0, 4'd0, 1'b0, 4'd15, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    #1;
    n_total++; if (fwd_c !== 2'b00) $display("FAIL st_pc: got %b want 00", fwd_c); else n_pass++;
    tick();
    $display("test_store done");
  endtask

  task automatic test_branch();
    set_id(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
    #1;
    n_total++; if (if_id_flush !== 1'b1) $display("FAIL br_flush: got %b want 1", if_id_flush); else n_pass++;
    tick();
    idle();
    #1;
    n_total++; if (if_id_flush !== 1'b0) $display("FAIL br_once: got %b want 0", if_id_flush); else n_pass++;
    tick();
    $display("test_branch done");
  endtask

  task automatic test_branch_stall();
    set_id(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 4'd3, 1'b0);  // LDR R3
    tick();
    set_id(4'd3, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
    #1;
    n_total++; if (if_id_flush !== 1'b0) $display("FAIL brst_flush0: got %b want 0", if_id_flush); else n_pass++;
    n_total++; if (pc_enable !== 1'b0) $display("FAIL brst_pc: got %b want 0", pc_enable); else n_pass++;
    tick();
    n_total++; if (if_id_flush !== 1'b1) $display("FAIL brst_flush1: got %b want 1", if_id_flush); else n_pass++;
    n_total++; if (stall_count !== 16'd2) $display("FAIL brst_cnt: got %0d want 2", stall_count); else n_pass++;
    idle();
    tick();
    $display("test_branch_stall done");
  endtask

  task automatic test_saturation();
    idle();
    tick();
    // Self-dependent loads stall on every second cycle: 40 cycles give 20 stalls.
    for (int i = 0; i < 40; i++) begin
      set_id(4'd2, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 4'd2, 1'b0);
      tick();
    end
    idle();
    #1;
    n_total++; if (stall_count !== 16'd22) $display("FAIL sat_wide: got %0d want 22", stall_count); else n_pass++;
    n_total++; if (s_stall_count !== 4'hF) $display("FAIL sat_narrow: got %0d want 15", s_stall_count); else n_pass++;
    tick();
    $display("test_saturation done");
  endtask

  task automatic test_reset_mid_stall();
    set_id(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd6, 1'b0);  // ADD R6
    tick();
    set_id(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 4'd4, 1'b0);  // LDR R4
    tick();
    set_id(4'd4, 1'b1, 4'd6, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    #1;
    n_total++; if (if_id_enable !== 1'b0) $display("FAIL rms_stall: got %b want 0", if_id_enable); else n_pass++;
    reset = 1'b1;
    #1;
    n_total++; if (if_id_enable !== 1'b1) $display("FAIL rms_drop: got %b want 1", if_id_enable); else n_pass++;
    tick();
    n_total++; if (stall_count !== 16'd0) $display("FAIL rms_cnt: got %0d want 0", stall_count); else n_pass++;
    reset = 1'b0;
    #1;
    n_total++; if (pc_enable !== 1'b1) $display("FAIL rms_pc: got %b want 1", pc_enable); else n_pass++;
    n_total++; if (fwd_a !== 2'b00) $display("FAIL rms_fwd_a: got %b want 00", fwd_a); else n_pass++;
    n_total++; if (fwd_b !== 2'b00) $display("FAIL rms_fwd_b: got %b want 00", fwd_b); else n_pass++;
    tick();
    $display("test_reset_mid_stall done");
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_forward();
    test_load_use();
    test_store();
    test_branch();
    test_branch_stall();
    test_saturation();
    test_reset_mid_stall();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
